// File: rtl/fads_pkg.sv
// Shared definitions for the FADS sort scheduler: register offsets, FSM state
// encoding and configuration defaults.
package fads_pkg;

    localparam int TSW_DEF = 32;

    localparam logic [19:0] ADDR_CTRL     = 20'h00;
    localparam logic [19:0] ADDR_DELAY    = 20'h04;
    localparam logic [19:0] ADDR_DURATION = 20'h08;
    localparam logic [19:0] ADDR_STATUS   = 20'h0C;
    localparam logic [19:0] ADDR_FIRED    = 20'h10;
    localparam logic [19:0] ADDR_DROPPED  = 20'h14;
    localparam logic [19:0] ADDR_MERGED   = 20'h18;

    localparam logic [31:0] DEF_SORT_DURATION = 32'd125;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        PULSE = 2'd2
    } sched_state_e;

endpackage

// File: rtl/red_pitaya_fads_fifo.sv
// Synchronous first-word-fall-through FIFO of due timestamps (depth 2**QSZ).
// A push is accepted while full when a pop happens in the same cycle.
module red_pitaya_fads_fifo #(
    parameter int QSZ = 4,
    parameter int TSW = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           push_i,
    input  logic [TSW-1:0] data_i,
    input  logic           pop_i,
    input  logic           flush_i,
    output logic [TSW-1:0] head_o,
    output logic [QSZ:0]   level_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int DEPTH = 1 << QSZ;

    logic [TSW-1:0] mem_q [DEPTH];
    logic [QSZ-1:0] wr_ptr_q, wr_ptr_d;
    logic [QSZ-1:0] rd_ptr_q, rd_ptr_d;
    logic [QSZ:0]   level_q, level_d;
    logic           full_q;
    logic           push_ok;
    logic           pop_ok;

    assign pop_ok  = pop_i && (level_q != '0);
    assign push_ok = push_i && (!full_q || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + QSZ'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + QSZ'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + (QSZ+1)'(1);
                2'b01:   level_d = level_q - (QSZ+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == (QSZ+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = full_q;
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/red_pitaya_fads_sort_sched.sv
// FADS sort pulse scheduler: timestamps detector requests and releases each as a
// sort trigger sort_delay cycles later. Define FADS_SCHED_STATS_EN for counters.
module red_pitaya_fads_sort_sched
    import fads_pkg::*;
#(
    parameter int             QSZ      = 4,
    parameter int             TSW      = fads_pkg::TSW_DEF,
    parameter logic [TSW-1:0] NOW_INIT = '0
) (
    input  logic        adc_clk_i,
    input  logic        adc_rst_i,
    input  logic        sort_req_i,
    output logic        sort_trig_o,
    output logic        queue_full_o,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic [3:0]  sys_sel,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);

    logic [TSW-1:0] now_q;
    logic           enable_q;
    logic [30:0]    delay_q;
    logic [31:0]    duration_q;
    sched_state_e   state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic           trig_q, trig_d;
    logic           ack_q;
    logic [31:0]    rdata_q, rdata_d;

    logic [19:0]    addr;
    logic           wr_ctrl;
    logic           flush;
    logic           push_req;
    logic           pop;
    logic           fire;
    logic           merge;
    logic           drop;
    logic           head_due;
    logic [TSW-1:0] head_diff;
    logic [31:0]    dur_load;

    logic [TSW-1:0] fifo_head;
    logic [QSZ:0]   fifo_level;
    logic           fifo_full;
    logic           fifo_empty;

    logic [31:0]    fired_cnt, dropped_cnt, merged_cnt;

    assign addr    = sys_addr[19:0];
    assign wr_ctrl = sys_wen && (addr == ADDR_CTRL);
    // Disabled means continuously flushed; the ctrl flush bit acts in its write cycle.
    assign flush    = (wr_ctrl && sys_wdata[1]) || !enable_q;
    assign push_req = sort_req_i && !flush;
    assign drop     = push_req && fifo_full && !pop;

    // Difference sign gives a wrap-safe "now has reached due" test.
    assign head_diff = now_q - fifo_head;
    assign head_due  = !fifo_empty && !head_diff[TSW-1];
    assign dur_load  = (duration_q == '0) ? 32'd1 : duration_q;

    red_pitaya_fads_fifo #(
        .QSZ (QSZ),
        .TSW (TSW)
    ) u_fifo (
        .clk_i   (adc_clk_i),
        .rst_i   (adc_rst_i),
        .push_i  (push_req),
        .data_i  (now_q + TSW'(delay_q)),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        fire    = 1'b0;
        merge   = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push_req) state_d = WAIT;
                end
                WAIT: begin
                    if (head_due) begin
                        pop     = 1'b1;
                        fire    = 1'b1;
                        cnt_d   = dur_load;
                        state_d = PULSE;
                    end else if (fifo_empty && !push_req) begin
                        state_d = IDLE;
                    end
                end
                PULSE: begin
                    if (head_due) begin
                        pop   = 1'b1;
                        fire  = 1'b1;
                        merge = 1'b1;
                        cnt_d = dur_load;
                    end else if (cnt_q <= 32'd1) begin
                        cnt_d   = '0;
                        state_d = (!fifo_empty || push_req) ? WAIT : IDLE;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Trigger follows PULSE one cycle later, but drops immediately on a flush.
    assign trig_d = (state_q == PULSE) && !flush;

    always_comb begin
        rdata_d = '0;
        if (sys_ren) begin
            case (addr)
                ADDR_CTRL:     rdata_d[0] = enable_q;
                ADDR_DELAY:    rdata_d    = {1'b0, delay_q};
                ADDR_DURATION: rdata_d    = duration_q;
                ADDR_STATUS: begin
                    rdata_d[QSZ:0]  = fifo_level;
                    rdata_d[17:16]  = state_q;
                    rdata_d[20]     = fifo_full;
                end
                ADDR_FIRED:    rdata_d    = fired_cnt;
                ADDR_DROPPED:  rdata_d    = dropped_cnt;
                ADDR_MERGED:   rdata_d    = merged_cnt;
                default:       rdata_d    = '0;
            endcase
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            now_q   <= NOW_INIT;
            state_q <= IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            now_q   <= now_q + TSW'(1);
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            ack_q   <= sys_wen || sys_ren;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            enable_q   <= 1'b0;
            delay_q    <= '0;
            duration_q <= DEF_SORT_DURATION;
        end else if (sys_wen) begin
            case (addr)
                ADDR_CTRL:     enable_q   <= sys_wdata[0];
                ADDR_DELAY:    delay_q    <= sys_wdata[30:0];
                ADDR_DURATION: duration_q <= sys_wdata;
                default: ;
            endcase
        end
    end

`ifdef FADS_SCHED_STATS_EN
    logic        clr_cnt;
    logic [31:0] fired_q, dropped_q, merged_q;

    assign clr_cnt = wr_ctrl && sys_wdata[2];

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i || clr_cnt) begin
            fired_q   <= '0;
            dropped_q <= '0;
            merged_q  <= '0;
        end else begin
            if (fire  && (fired_q   != '1)) fired_q   <= fired_q   + 32'd1;
            if (drop  && (dropped_q != '1)) dropped_q <= dropped_q + 32'd1;
            if (merge && (merged_q  != '1)) merged_q  <= merged_q  + 32'd1;
        end
    end

    assign fired_cnt   = fired_q;
    assign dropped_cnt = dropped_q;
    assign merged_cnt  = merged_q;
`else
    assign fired_cnt   = '0;
    assign dropped_cnt = '0;
    assign merged_cnt  = '0;
`endif

    logic unused_sig;
    assign unused_sig = ^{sys_sel, sys_addr[31:20], sys_wdata, fire, drop, merge};

    assign sort_trig_o  = trig_q;
    assign queue_full_o = fifo_full;
    assign sys_rdata    = rdata_q;
    assign sys_ack      = ack_q;
    assign sys_err      = 1'b0;

endmodule
